// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The core drives the request side (master); the unit drives status and result (slave).
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one iteration per cycle, sign fixed up on the final cycle. Divide-by-zero and
// signed overflow bypass the iteration and finish one cycle after acceptance.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] mag_q, mag_d;       // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_q, hi_d;         // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;         // multiplier / quotient / special result
    logic [XLEN-1:0] result_q, result_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            special_q, special_d;

    logic            accept;
    logic            last;
    logic            a_signed, b_signed, sa, sb, is_special;
    logic [XLEN-1:0] a_mag, b_mag, spec_val, final_val;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_s;

    assign accept = (state_q != StCalc) && bus.start;
    assign last   = special_q || (cnt_q == CntW'(XLEN));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic; DONE accepts start exactly like IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StCalc;
            StCalc:  if (last) state_d = StDone;
            StDone:  state_d = bus.start ? StCalc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        bus.busy = (state_q == StCalc);
        bus.done = (state_q == StDone);
    end

    assign bus.result = result_q;
    assign bus.zero   = (result_q == '0);

    // Operand decode: signedness, magnitudes and the single-cycle special cases
    always_comb begin
        a_signed   = bus.op inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed   = bus.op inside {3'b001, 3'b100, 3'b110};
        sa         = a_signed && bus.a[XLEN-1];
        sb         = b_signed && bus.b[XLEN-1];
        a_mag      = sa ? -bus.a : bus.a;
        b_mag      = sb ? -bus.b : bus.b;
        is_special = bus.op[2] && ((bus.b == '0) ||
                     (!bus.op[0] && (bus.a == MinVal) && (bus.b == '1)));
        if (bus.b == '0) spec_val = bus.op[1] ? bus.a : '1;
        else             spec_val = bus.op[1] ? '0 : MinVal;
    end

    // One iteration step plus the sign-corrected final value
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        final_val = '0;
        if (special_q) begin
            final_val = lo_q;
        end else begin
            unique case (op_q)
                3'b000:                 final_val = prod_s[XLEN-1:0];
                3'b001, 3'b010, 3'b011: final_val = prod_s[2*XLEN-1:XLEN];
                3'b100, 3'b101:         final_val = neg_q ? -lo_q : lo_q;
                default:                final_val = neg_q ? -hi_q : hi_q;
            endcase
        end
    end

    // Datapath next-state: latch on accept, iterate in CALC, write result on the last cycle
    always_comb begin
        op_d      = op_q;
        mag_d     = mag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        special_d = special_q;
        if (accept) begin
            op_d      = bus.op;
            cnt_d     = '0;
            special_d = is_special;
            hi_d      = '0;
            // Remainder takes the dividend's sign; product and quotient take sa^sb
            neg_d     = (bus.op[2] && bus.op[1]) ? sa : (sa ^ sb);
            mag_d     = bus.op[2] ? b_mag : a_mag;
            lo_d      = bus.op[2] ? a_mag : b_mag;
            if (is_special) lo_d = spec_val;
        end else if (state_q == StCalc) begin
            if (last) begin
                result_d = final_val;
            end else begin
                cnt_d = cnt_q + CntW'(1);
                if (!op_q[2]) begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end else if (!div_diff[XLEN]) begin
                    hi_d = div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            mag_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            mag_q     <= mag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            special_q <= special_d;
        end
    end
endmodule
